load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage directly downstream of the ALU. Consumes the ALU's 10-bit byte
//  address (ram_address) plus rt store data and runs one load/store on a synchronous word RAM.
//  Handles byte lanes, sign/zero extension and misalignment. Stalls the CPU until completion.
// PARAMETERS
//  ADDR_W      10  byte-address width from the ALU; word address = ADDR_W-2 bits
//  DATA_W      32  data width; fixed at 32, other values unsupported
//  RD_LATENCY  1   cycles from mem_re high to mem_rdata valid; legal 1..4
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  req          in   1        access request; held high until done; sampled only in IDLE
//  mem_op       in   3        000 LB,001 LH,010 LW,011 SB,100 LBU,101 LHU,110 SH,111 SW
//  ram_address  in   ADDR_W   byte address from the ALU
//  store_data   in   32       rt value for stores
//  stall        out  1        freeze PC/pipeline
//  done         out  1        one-cycle completion pulse
//  misaligned   out  1        valid with done; access was aborted
//  load_data    out  32       extended load result; held until next successful load
//  mem_addr     out  ADDR_W-2 RAM word address
//  mem_wdata    out  32       RAM write data (lane-replicated)
//  mem_be       out  4        RAM byte enables; bit i = bits [8i+7:8i]
//  mem_we       out  1        RAM write strobe
//  mem_re       out  1        RAM read strobe
//  mem_rdata    in   32       RAM read data
// BEHAVIOUR
//  Reset (async): state IDLE; every output, the wait counter and the op/addr/data capture regs = 0.
//  FSM: IDLE, RD_ISSUE, RD_WAIT, WR, DONE. Cycle 0 = the IDLE cycle with req=1.
//  IDLE: on req, register mem_op, ram_address and store_data.
//   If misaligned -> DONE with misaligned=1 and no RAM strobe.
//   Else a load -> RD_ISSUE; a store -> WR.
//  Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Byte ops never misalign.
//  RD_ISSUE (cycle 1): mem_re=1 for exactly one cycle; wait counter loads RD_LATENCY.
//  RD_WAIT: counter decrements; when it reaches 0, register the extended mem_rdata into load_data
//   -> DONE. The done pulse is at cycle 2+RD_LATENCY.
//  WR (cycle 1): mem_we=1 for one cycle with mem_be/mem_wdata -> DONE. done is at cycle 2.
//  DONE: done=1 for one cycle -> IDLE. req is not accepted in DONE, so the minimum gap between
//   accepts is one IDLE cycle.
//  stall = (IDLE & req) | (state not in {IDLE,DONE}). Combinational, so the accept cycle stalls.
//  Lanes are little-endian with lane = addr[1:0].
//   SB: be = 1<<lane; wdata = {4{sd[7:0]}}.
//   SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{sd[15:0]}}.
//   SW: be = 4'b1111.
//  Loads select the lane byte/half; LB/LH sign-extend, LBU/LHU zero-extend; LW passes through.
//  mem_addr = captured addr[ADDR_W-1:2], driven from RD_ISSUE/WR through DONE; 0 in IDLE.
//  Strobes are registered state decodes, never combinational from req.
//  req dropping mid-access is a protocol violation; the access still completes.
//  misaligned clears on the next accept. load_data is unchanged by stores and aborted loads.
//  Reset mid-access: strobes drop immediately, no done, and the captured access is discarded.
// STRUCTURE
//  lsu_pkg: MEM_OP_* encodings, state localparams, and the is_store / size decode functions.
//  Sub-module lsu_lane_align (combinational) computes be/wdata replication and the load
//   lane extract + extend. The FSM, counter and capture regs stay in load_store_unit.
// TESTING
//  1 SW addr=0x010 sd=0xDEADBEEF -> cycle1 we=1 be=1111 mem_addr=0x04; done at cycle 2.
//  2 LB addr=0x013 rdata=0x80FF7F01 (RD_LATENCY=1) -> load_data=0xFFFFFF80, done at cycle 3;
//    LBU -> 0x00000080.
//  3 SH addr=0x006 sd=0x1234ABCD -> be=1100, wdata=0xABCDABCD; LH addr=0x001 -> misaligned=1,
//    done at cycle 1, no strobe, load_data held.
//  4 RD_LATENCY=3, LW addr=0x3FC -> mem_addr=0xFF, re for one cycle, done at cycle 5,
//    stall high cycles 0-4.
//  5 Reset asserted in RD_WAIT -> re/we/done/stall=0 immediately; next req starts cleanly
//    from IDLE.
//  6 Back-to-back SB then LBU on the same byte, req held -> second accept one cycle after done;
//    read returns the stored byte zero-extended.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the load/store unit: memory-op encodings, access
//   sizes, the FSM state type, the wait-counter width and small op-decode
//   helpers used by both load_store_unit and lsu_lane_align.
package lsu_pkg;

  localparam logic [2:0] MEM_OP_LB  = 3'b000;
  localparam logic [2:0] MEM_OP_LH  = 3'b001;
  localparam logic [2:0] MEM_OP_LW  = 3'b010;
  localparam logic [2:0] MEM_OP_SB  = 3'b011;
  localparam logic [2:0] MEM_OP_LBU = 3'b100;
  localparam logic [2:0] MEM_OP_LHU = 3'b101;
  localparam logic [2:0] MEM_OP_SH  = 3'b110;
  localparam logic [2:0] MEM_OP_SW  = 3'b111;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Wide enough to hold the largest legal read latency (4).
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR       = 3'd3,
    ST_DONE     = 3'd4
  } lsu_state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [2:0] op);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return SIZE_HALF;
      MEM_OP_LW, MEM_OP_SW:             return SIZE_WORD;
      default:                          return SIZE_BYTE;
    endcase
  endfunction

  function automatic logic is_unsigned_load(input logic [2:0] op);
    return (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op_size(op))
      SIZE_HALF: return lo[0];
      SIZE_WORD: return lo != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
//   Purely combinational byte-lane steering for a 32-bit little-endian word RAM.
//   Store side: byte enables and lane-replicated write data.
//   Load side: lane byte/half extraction with sign or zero extension.
// Ports
//   op         in  3   memory op (lsu_pkg MEM_OP_* encoding)
//   lane       in  2   byte address bits [1:0]
//   store_data in  32  rt value for stores
//   rdata      in  32  raw RAM read word
//   be         out 4   byte enables for stores (bit i = bits [8i+7:8i])
//   wdata      out 32  replicated write data
//   load_ext   out 32  extended load result
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        uns;

  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (op_size(op))
      SIZE_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    lane_byte = rdata[7:0];
    case (lane)
      2'd0: lane_byte = rdata[7:0];
      2'd1: lane_byte = rdata[15:8];
      2'd2: lane_byte = rdata[23:16];
      2'd3: lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = lane[1] ? rdata[31:16] : rdata[15:0];
    uns       = is_unsigned_load(op);

    load_ext = rdata;
    case (op_size(op))
      SIZE_BYTE: load_ext = uns ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_ext = uns ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default:   load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory access stage after the ALU. Runs one load or store per request
//   on a synchronous word RAM, handling byte lanes, extension and misalignment,
//   and stalls the pipeline until the access completes.
//
//   Handshake: the CPU raises req and holds it (with mem_op/ram_address/
//   store_data stable) until done. req is sampled only in IDLE; the accept cycle
//   already stalls. done is a single-cycle pulse, misaligned is valid with it.
//   DONE never accepts, so consecutive accepts are at least one IDLE apart.
//
// Ports
//   clk, reset    clock, asynchronous active-high reset
//   req, mem_op, ram_address, store_data   request from the pipeline
//   stall, done, misaligned, load_data     status / result to the pipeline
//   mem_addr, mem_wdata, mem_be, mem_we, mem_re, mem_rdata   word RAM port
//   dbg_state     current FSM state (lsu_state_t encoding)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              done,
  output logic              misaligned,
  output logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  lsu_state_t        state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sd_q;
  logic              mis_q;
  logic [DATA_W-1:0] ld_q;

  logic [3:0]        be_a;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] ext_a;
  logic              req_mis;

  assign req_mis = is_misaligned(mem_op, ram_address[1:0]);

  lsu_lane_align u_align (
    .op         (op_q),
    .lane       (addr_q[1:0]),
    .store_data (sd_q),
    .rdata      (mem_rdata),
    .be         (be_a),
    .wdata      (wdata_a),
    .load_ext   (ext_a)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (req_mis)               state_d = ST_DONE;
          else if (is_store(mem_op)) state_d = ST_WR;
          else                       state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      // The count reaches 0 on this cycle's decrement: the read data is valid now.
      ST_RD_WAIT:  if (cnt == CNT_W'(1)) state_d = ST_DONE;
      ST_WR:       state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= '0;
      addr_q <= '0;
      sd_q   <= '0;
      mis_q  <= 1'b0;
      ld_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q   <= mem_op;
            addr_q <= ram_address;
            sd_q   <= store_data;
            mis_q  <= req_mis;
          end
        end
        ST_RD_ISSUE: cnt <= CNT_W'(RD_LATENCY);
        ST_RD_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) ld_q <= ext_a;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode the registered state only, so reset removes them at once.
  always_comb begin
    mem_re    = (state == ST_RD_ISSUE);
    mem_we    = (state == ST_WR);
    done      = (state == ST_DONE);
    mem_be    = (state == ST_WR) ? be_a : 4'b0000;
    mem_wdata = (state == ST_WR) ? wdata_a : '0;
    mem_addr  = (state != ST_IDLE) ? addr_q[ADDR_W-1:2] : '0;
    // Gated by reset so a held req cannot raise stall while the unit is in reset.
    stall     = !reset && (((state == ST_IDLE) && req) ||
                           ((state != ST_IDLE) && (state != ST_DONE)));
  end

  assign misaligned = mis_q;
  assign load_data  = ld_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- DUT with RD_LATENCY=1 ----------------
  logic        req1, stall1, done1, mis1, we1, re1;
  logic [2:0]  op1, st1;
  logic [9:0]  addr1;
  logic [31:0] sd1, ld1, wdata1, rdata1;
  logic [7:0]  maddr1;
  logic [3:0]  be1;

  load_store_unit #(.ADDR_W(10), .DATA_W(32), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .mem_op(op1), .ram_address(addr1),
    .store_data(sd1), .stall(stall1), .done(done1), .misaligned(mis1),
    .load_data(ld1), .mem_addr(maddr1), .mem_wdata(wdata1), .mem_be(be1),
    .mem_we(we1), .mem_re(re1), .mem_rdata(rdata1), .dbg_state(st1)
  );

  // ---------------- DUT with RD_LATENCY=3 ----------------
  logic        req3, stall3, done3, mis3, we3, re3;
  logic [2:0]  op3, st3;
  logic [9:0]  addr3;
  logic [31:0] sd3, ld3, wdata3, rdata3;
  logic [7:0]  maddr3;
  logic [3:0]  be3;

  load_store_unit #(.ADDR_W(10), .DATA_W(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .mem_op(op3), .ram_address(addr3),
    .store_data(sd3), .stall(stall3), .done(done3), .misaligned(mis3),
    .load_data(ld3), .mem_addr(maddr3), .mem_wdata(wdata3), .mem_be(be3),
    .mem_we(we3), .mem_re(re3), .mem_rdata(rdata3), .dbg_state(st3)
  );

  // ---------------- RAM models ----------------
  // Read data is present only in the single cycle RD_LATENCY after mem_re,
  // zero otherwise, so a capture on the wrong cycle returns 0.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic        pre1_en, pre3_en;
  logic [7:0]  pre1_a, pre3_a;
  logic [31:0] pre1_d, pre3_d;
  logic [31:0] p3_a, p3_b;

  always @(posedge clk) begin
    if (pre1_en) mem1[pre1_a] <= pre1_d;
    if (we1)
      for (int b = 0; b < 4; b++)
        if (be1[b]) mem1[maddr1][8*b +: 8] <= wdata1[8*b +: 8];
    rdata1 <= re1 ? mem1[maddr1] : 32'h0;
  end

  always @(posedge clk) begin
    if (pre3_en) mem3[pre3_a] <= pre3_d;
    if (we3)
      for (int b = 0; b < 4; b++)
        if (be3[b]) mem3[maddr3][8*b +: 8] <= wdata3[8*b +: 8];
    p3_a   <= re3 ? mem3[maddr3] : 32'h0;
    p3_b   <= p3_a;
    rdata3 <= p3_b;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    reset = 1'b1;
    req1 = 0; op1 = 0; addr1 = 0; sd1 = 0;
    req3 = 0; op3 = 0; addr3 = 0; sd3 = 0;
    pre1_en = 0; pre1_a = 0; pre1_d = 0;
    pre3_en = 0; pre3_a = 0; pre3_d = 0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // reset state
    chk("rst_state", {29'h0, st1}, 32'(ST_IDLE));
    chk("rst_stall", {31'h0, stall1}, 32'h0);
    chk("rst_done", {31'h0, done1}, 32'h0);
    chk("rst_mis", {31'h0, mis1}, 32'h0);
    chk("rst_ld", ld1, 32'h0);
    chk("rst_strobes", {30'h0, we1, re1}, 32'h0);
    chk("rst_maddr", {24'h0, maddr1}, 32'h0);

    // 1: SW addr 0x010
    op1 = MEM_OP_SW; addr1 = 10'h010; sd1 = 32'hDEADBEEF; req1 = 1; #1;
    chk("t1_c0_stall", {31'h0, stall1}, 32'h1);
    chk("t1_c0_we", {31'h0, we1}, 32'h0);
    cyc();
    chk("t1_c1_we", {31'h0, we1}, 32'h1);
    chk("t1_c1_be", {28'h0, be1}, 32'hF);
    chk("t1_c1_maddr", {24'h0, maddr1}, 32'h04);
    chk("t1_c1_wdata", wdata1, 32'hDEADBEEF);
    chk("t1_c1_done", {31'h0, done1}, 32'h0);
    cyc();
    chk("t1_c2_done", {31'h0, done1}, 32'h1);
    chk("t1_c2_stall", {31'h0, stall1}, 32'h0);
    chk("t1_mem", mem1[4], 32'hDEADBEEF);
    req1 = 0;
    cyc();
    pre1_en = 1; pre1_a = 8'h04; pre1_d = 32'h80FF7F01;

    // 2: LB addr 0x013 then LBU
    cyc();
    pre1_en = 0;
    op1 = MEM_OP_LB; addr1 = 10'h013; req1 = 1;
    cyc();
    chk("t2_c1_re", {31'h0, re1}, 32'h1);
    chk("t2_c1_maddr", {24'h0, maddr1}, 32'h04);
    cyc();
    chk("t2_c2_done", {31'h0, done1}, 32'h0);
    chk("t2_c2_stall", {31'h0, stall1}, 32'h1);
    cyc();
    chk("t2_c3_done", {31'h0, done1}, 32'h1);
    chk("t2_lb", ld1, 32'hFFFFFF80);
    req1 = 0;
    cyc();
    op1 = MEM_OP_LBU; addr1 = 10'h013; req1 = 1;
    cyc(); cyc(); cyc();
    chk("t2_lbu_done", {31'h0, done1}, 32'h1);
    chk("t2_lbu", ld1, 32'h00000080);
    req1 = 0;
    cyc();

    // 3: SH addr 0x006, then misaligned LH addr 0x001
    op1 = MEM_OP_SH; addr1 = 10'h006; sd1 = 32'h1234ABCD; req1 = 1;
    cyc();
    chk("t3_sh_be", {28'h0, be1}, 32'hC);
    chk("t3_sh_wdata", wdata1, 32'hABCDABCD);
    chk("t3_sh_maddr", {24'h0, maddr1}, 32'h01);
    cyc();
    chk("t3_sh_done", {31'h0, done1}, 32'h1);
    chk("t3_sh_mis", {31'h0, mis1}, 32'h0);
    chk("t3_sh_mem", mem1[1], 32'hABCD0000);
    req1 = 0;
    cyc();
    op1 = MEM_OP_LH; addr1 = 10'h001; req1 = 1; #1;
    chk("t3_lh_c0_stall", {31'h0, stall1}, 32'h1);
    cyc();
    chk("t3_lh_done", {31'h0, done1}, 32'h1);
    chk("t3_lh_mis", {31'h0, mis1}, 32'h1);
    chk("t3_lh_strobes", {30'h0, we1, re1}, 32'h0);
    chk("t3_lh_stall", {31'h0, stall1}, 32'h0);
    chk("t3_lh_ld_held", ld1, 32'h00000080);
    req1 = 0;
    cyc();
    chk("t3_idle_mis_held", {31'h0, mis1}, 32'h1);

    // 6: back-to-back SB then LBU on the same byte, req held throughout
    op1 = MEM_OP_SB; addr1 = 10'h021; sd1 = 32'h000000A5; req1 = 1;
    cyc();
    chk("t6_sb_be", {28'h0, be1}, 32'h2);
    chk("t6_sb_wdata", wdata1, 32'hA5A5A5A5);
    chk("t6_sb_maddr", {24'h0, maddr1}, 32'h08);
    cyc();
    chk("t6_sb_done", {31'h0, done1}, 32'h1);
    chk("t6_sb_mis_clr", {31'h0, mis1}, 32'h0);
    op1 = MEM_OP_LBU;
    cyc();
    chk("t6_acc_state", {29'h0, st1}, 32'(ST_IDLE));
    chk("t6_acc_stall", {31'h0, stall1}, 32'h1);
    cyc();
    chk("t6_lbu_re", {31'h0, re1}, 32'h1);
    cyc(); cyc();
    chk("t6_lbu_done", {31'h0, done1}, 32'h1);
    chk("t6_lbu_data", ld1, 32'h000000A5);
    req1 = 0;
    cyc();

    // 4: RD_LATENCY=3, LW addr 0x3FC
    pre3_en = 1; pre3_a = 8'hFF; pre3_d = 32'hCAFEF00D;
    cyc();
    pre3_en = 0;
    op3 = MEM_OP_LW; addr3 = 10'h3FC; req3 = 1; #1;
    chk("t4_c0_stall", {31'h0, stall3}, 32'h1);
    cyc();
    chk("t4_c1_re", {31'h0, re3}, 32'h1);
    chk("t4_c1_maddr", {24'h0, maddr3}, 32'hFF);
    chk("t4_c1_stall", {31'h0, stall3}, 32'h1);
    cyc();
    chk("t4_c2_re", {31'h0, re3}, 32'h0);
    chk("t4_c2_stall", {31'h0, stall3}, 32'h1);
    cyc();
    chk("t4_c3_stall", {31'h0, stall3}, 32'h1);
    cyc();
    chk("t4_c4_stall", {31'h0, stall3}, 32'h1);
    chk("t4_c4_done", {31'h0, done3}, 32'h0);
    cyc();
    chk("t4_c5_done", {31'h0, done3}, 32'h1);
    chk("t4_c5_stall", {31'h0, stall3}, 32'h0);
    chk("t4_data", ld3, 32'hCAFEF00D);
    req3 = 0;
    cyc();

    // 5: reset in RD_WAIT, then a clean access
    pre3_en = 1; pre3_a = 8'h40; pre3_d = 32'h11111111;
    cyc();
    pre3_en = 0;
    op3 = MEM_OP_LW; addr3 = 10'h100; req3 = 1;
    cyc();
    cyc();
    chk("t5_in_wait", {29'h0, st3}, 32'(ST_RD_WAIT));
    reset = 1'b1; #1;
    chk("t5_rst_strobes", {30'h0, we3, re3}, 32'h0);
    chk("t5_rst_done", {31'h0, done3}, 32'h0);
    chk("t5_rst_stall", {31'h0, stall3}, 32'h0);
    req3 = 0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("t5_post_state", {29'h0, st3}, 32'(ST_IDLE));
    chk("t5_post_ld", ld3, 32'h0);
    chk("t5_post_maddr", {24'h0, maddr3}, 32'h0);
    pre3_en = 1; pre3_a = 8'h41; pre3_d = 32'h22222222;
    cyc();
    pre3_en = 0;
    op3 = MEM_OP_LW; addr3 = 10'h104; req3 = 1;
    cyc();
    chk("t5_new_re", {31'h0, re3}, 32'h1);
    chk("t5_new_maddr", {24'h0, maddr3}, 32'h41);
    cyc(); cyc(); cyc();
    chk("t5_new_c4_done", {31'h0, done3}, 32'h0);
    cyc();
    chk("t5_new_done", {31'h0, done3}, 32'h1);
    chk("t5_new_data", ld3, 32'h22222222);
    req3 = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
